// File: rtl/avmm_bus_arbiter.sv
// Two-master Avalon-MM arbiter: one master owns the bus per transaction, held until the last
// read beat or the write response. Optional macro AVMM_ARB_FIXED_PRIO_EN gives m0 strict priority.
module avmm_bus_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BCW = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic [AW-1:0]     m0_address,
    input  logic [BCW-1:0]    m0_burstcount,
    input  logic [DW-1:0]     m0_writedata,
    input  logic [DW/8-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    output logic              m0_waitrequest,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_readdatavalid,
    output logic              m0_writeresponsevalid,
    output logic [1:0]        m0_response,

    input  logic [AW-1:0]     m1_address,
    input  logic [BCW-1:0]    m1_burstcount,
    input  logic [DW-1:0]     m1_writedata,
    input  logic [DW/8-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    output logic              m1_waitrequest,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_readdatavalid,
    output logic              m1_writeresponsevalid,
    output logic [1:0]        m1_response,

    output logic [AW-1:0]     s_address,
    output logic [BCW-1:0]    s_burstcount,
    output logic [DW-1:0]     s_writedata,
    output logic [DW/8-1:0]   s_byteenable,
    output logic              s_read,
    output logic              s_write,
    input  logic              s_waitrequest,
    input  logic [DW-1:0]     s_readdata,
    input  logic              s_readdatavalid,
    input  logic              s_writeresponsevalid,
    input  logic [1:0]        s_response
);

    typedef enum logic [1:0] {IDLE, CMD, RD_WAIT, WR_RESP} state_t;

    state_t         state, state_nxt;
    logic           grant, grant_nxt;
    logic           last_grant, last_grant_nxt;
    logic [BCW-1:0] beats, beats_nxt;
    logic           wr_active, wr_active_nxt;
    logic           cmd_open;
    logic           pick;

    logic           req0, req1;
    logic           g_read, g_write;
    logic [BCW-1:0] burst_len;
    logic [BCW-1:0] beats_dec;
    logic [BCW-1:0] wr_remaining;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Command path follows the registered grant
    assign g_read       = grant ? m1_read       : m0_read;
    assign g_write      = grant ? m1_write      : m0_write;
    assign s_address    = grant ? m1_address    : m0_address;
    assign s_burstcount = grant ? m1_burstcount : m0_burstcount;
    assign s_writedata  = grant ? m1_writedata  : m0_writedata;
    assign s_byteenable = grant ? m1_byteenable : m0_byteenable;

    assign burst_len    = (s_burstcount == '0) ? BCW'(1) : s_burstcount;
    assign beats_dec    = (beats == '0) ? '0 : beats - BCW'(1);
    assign wr_remaining = wr_active ? beats_dec : burst_len - BCW'(1);

`ifdef AVMM_ARB_FIXED_PRIO_EN
    assign pick = ~req0;
`else
    // On a tie the master that did not win last time takes the bus
    assign pick = (req0 & req1) ? ~last_grant : ~req0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beats      <= '0;
            wr_active  <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            beats      <= beats_nxt;
            wr_active  <= wr_active_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        beats_nxt      = beats;
        wr_active_nxt  = wr_active;
        s_read         = 1'b0;
        s_write        = 1'b0;
        cmd_open       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    grant_nxt     = pick;
                    wr_active_nxt = 1'b0;
                    state_nxt     = CMD;
                end
            end
            CMD: begin
                cmd_open = 1'b1;
                // Read wins a same-cycle read/write; an open write burst blocks reads
                s_read   = g_read & ~wr_active;
                s_write  = g_write & (wr_active | ~g_read);
                if (s_read && !s_waitrequest) begin
                    beats_nxt = burst_len;
                    state_nxt = RD_WAIT;
                end else if (s_write && !s_waitrequest) begin
                    beats_nxt = wr_remaining;
                    if (wr_remaining == '0) begin
                        wr_active_nxt = 1'b0;
                        state_nxt     = WR_RESP;
                    end else begin
                        wr_active_nxt = 1'b1;
                    end
                end else if (!wr_active && !g_read && !g_write) begin
                    // Master withdrew before anything was accepted: release the bus
                    state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                if (s_readdatavalid) begin
                    beats_nxt = beats_dec;
                    if (beats <= BCW'(1)) begin
                        last_grant_nxt = grant;
                        state_nxt      = IDLE;
                    end
                end
            end
            WR_RESP: begin
                if (s_writeresponsevalid) begin
                    last_grant_nxt = grant;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m0_waitrequest = ~(cmd_open & ~grant) | s_waitrequest;
    assign m1_waitrequest = ~(cmd_open &  grant) | s_waitrequest;

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;
    assign m0_response = s_response;
    assign m1_response = s_response;

    assign m0_readdatavalid      = (state == RD_WAIT) & ~grant & s_readdatavalid;
    assign m1_readdatavalid      = (state == RD_WAIT) &  grant & s_readdatavalid;
    assign m0_writeresponsevalid = (state == WR_RESP) & ~grant & s_writeresponsevalid;
    assign m1_writeresponsevalid = (state == WR_RESP) &  grant & s_writeresponsevalid;

endmodule

// File: tb/tb_avmm_bus_arbiter.sv
// Directed bench for avmm_bus_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_avmm_bus_arbiter;

    localparam int AW = 32, DW = 32, BCW = 5;

    logic clk_i = 1'b0, rst_ni;
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic [BCW-1:0] m0_burstcount, m1_burstcount, s_burstcount;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [DW/8-1:0] m0_byteenable, m1_byteenable, s_byteenable;
    logic m0_read, m0_write, m1_read, m1_write;
    logic m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic m0_readdatavalid, m1_readdatavalid, m0_writeresponsevalid, m1_writeresponsevalid;
    logic [1:0] m0_response, m1_response, s_response;
    logic s_read, s_write, s_waitrequest, s_readdatavalid, s_writeresponsevalid;

    int checks = 0, errors = 0;

    always #5 clk_i = ~clk_i;

    avmm_bus_arbiter #(.AW(AW), .DW(DW), .BCW(BCW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_writedata(m0_writedata),
        .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_writeresponsevalid(m0_writeresponsevalid),
        .m0_response(m0_response),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid), .m1_writeresponsevalid(m1_writeresponsevalid),
        .m1_response(m1_response),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_writedata(s_writedata),
        .s_byteenable(s_byteenable), .s_read(s_read), .s_write(s_write),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .s_writeresponsevalid(s_writeresponsevalid),
        .s_response(s_response)
    );

    // exp = {s_read, s_write, m0_wait, m1_wait, m0_rdv, m1_rdv, m0_wrv, m1_wrv, m0_response}
    typedef struct {
        logic       m0_rd, m0_wr;
        logic [4:0] m0_bc;
        logic       m1_rd, m1_wr;
        logic       s_wait, s_rdv, s_wrv;
        logic [1:0] s_resp;
        logic [9:0] exp;
    } vec_t;

    vec_t vec [12];

    function automatic vec_t mk(input logic m0r, input logic m0w, input logic [4:0] bc,
                                input logic m1r, input logic m1w, input logic sw,
                                input logic rdv, input logic wrv, input logic [1:0] resp,
                                input logic [9:0] exp);
        vec_t v;
        v.m0_rd = m0r; v.m0_wr = m0w; v.m0_bc = bc; v.m1_rd = m1r; v.m1_wr = m1w;
        v.s_wait = sw; v.s_rdv = rdv; v.s_wrv = wrv; v.s_resp = resp; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        m0_burstcount = 5'd1; m1_burstcount = 5'd1;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_writeresponsevalid = 1'b0;
        s_response = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle_in();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    function automatic logic [9:0] outs();
        return {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid,
                m1_readdatavalid, m0_writeresponsevalid, m1_writeresponsevalid, m0_response};
    endfunction

    initial begin
        int beats_seen;
        logic wr_held;
        logic [1:0] order [4];
        logic [1:0] exp_order [4];
        int n;
        logic pend;

        m0_address = 32'h100; m1_address = 32'h200;
        m0_writedata = 32'hA0A0_0000; m1_writedata = 32'hB1B1_0000;
        m0_byteenable = 4'hF; m1_byteenable = 4'h3;
        idle_in();
        rst_ni = 1'b0;
        #12;
        chk("reset_outputs", 64'(outs()), 64'(10'b0011000000));
        rst_ni = 1'b1;

        // m0 read burst of 4, stray valid in IDLE, then m0 write with error response
        vec[0]  = mk(1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 10'b0011000000);
        vec[1]  = mk(1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 10'b1001000000);
        vec[2]  = mk(1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 10'b0011100000);
        vec[3]  = mk(1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 10'b0011100000);
        vec[4]  = mk(1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 10'b0011100000);
        vec[5]  = mk(1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 10'b0011100000);
        vec[6]  = mk(1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 10'b0011000000);
        vec[7]  = mk(1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 10'b0011000000);
        vec[8]  = mk(1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 10'b0101000000);
        vec[9]  = mk(1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 10'b0011000000);
        vec[10] = mk(1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 10'b0011001010);
        vec[11] = mk(1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 10'b0011000010);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            m0_read = vec[i].m0_rd; m0_write = vec[i].m0_wr; m0_burstcount = vec[i].m0_bc;
            m1_read = vec[i].m1_rd; m1_write = vec[i].m1_wr;
            s_waitrequest = vec[i].s_wait; s_readdatavalid = vec[i].s_rdv;
            s_writeresponsevalid = vec[i].s_wrv; s_response = vec[i].s_resp;
            #2;
            chk($sformatf("vec%0d", i), 64'(outs()), 64'(vec[i].exp));
            if (i == 1) chk("vec1_s_address", 64'(s_address), 64'h100);
        end

        // m1 write burst of 3 with two stall cycles on beat 2; m0 asks meanwhile
        @(negedge clk_i);
        idle_in();
        m1_write = 1'b1; m1_burstcount = 5'd3;
        beats_seen = 0; wr_held = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            s_waitrequest = (c == 1 || c == 2);
            #2;
            wr_held &= s_write & (m1_waitrequest == s_waitrequest) & m0_waitrequest;
            if (s_write && !s_waitrequest) beats_seen++;
        end
        chk("wr_beats", 64'(beats_seen), 64'd3);
        chk("wr_held_stall", 64'(wr_held), 64'd1);
        @(negedge clk_i);
        m1_write = 1'b0; s_waitrequest = 1'b0; m0_read = 1'b1;
        #2;
        chk("wr_resp_wait", 64'({s_read, s_write, m0_waitrequest, m1_waitrequest}), 64'b0011);
        @(negedge clk_i);
        s_writeresponsevalid = 1'b1;
        #2;
        chk("wr_resp_m1", 64'({m0_writeresponsevalid, m1_writeresponsevalid}), 64'b01);
        @(negedge clk_i);
        s_writeresponsevalid = 1'b0; m0_burstcount = 5'd0;
        #2;
        chk("m0_wait_after_wr", 64'(m0_waitrequest), 64'd1);

        // m0 read with burstcount 0 behaves as a single beat
        @(negedge clk_i);
        #2;
        chk("bc0_accept", 64'({s_read, m0_waitrequest, s_burstcount}), 64'({1'b1, 1'b0, 5'd0}));
        @(negedge clk_i);
        m0_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 32'hDEAD_BEEF;
        #2;
        chk("bc0_beat", 64'({m0_readdatavalid, m0_readdata}), 64'({1'b1, 32'hDEAD_BEEF}));
        @(negedge clk_i);
        #2;
        chk("bc0_extra_dropped", 64'(m0_readdatavalid), 64'd0);

        // Reset pulse mid read burst: late valids go nowhere
        @(negedge clk_i);
        idle_in();
        m0_read = 1'b1; m0_burstcount = 5'd4;
        @(negedge clk_i);
        @(negedge clk_i);
        m0_read = 1'b0; s_readdatavalid = 1'b1;
        #2;
        chk("rst_beat1", 64'(m0_readdatavalid), 64'd1);
        @(negedge clk_i);
        #2;
        chk("rst_beat2", 64'(m0_readdatavalid), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #2;
        chk("rst_mid_outputs", 64'(outs()), 64'(10'b0011000000));
        @(negedge clk_i);
        rst_ni = 1'b1;
        #2;
        chk("rst_late_valid", 64'({m0_readdatavalid, m1_readdatavalid}), 64'b00);
        @(negedge clk_i);
        #2;
        chk("rst_late_valid2", 64'({m0_readdatavalid, m1_readdatavalid}), 64'b00);

        // Both masters stream single reads right after reset
        @(negedge clk_i);
        idle_in();
        m0_read = 1'b1; m1_read = 1'b1;
        n = 0; pend = 1'b0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk_i);
            s_readdatavalid = pend;
            pend = 1'b0;
            #2;
            if (s_read) begin
                order[n] = !m0_waitrequest ? 2'd0 : (!m1_waitrequest ? 2'd1 : 2'd2);
                n++;
                pend = 1'b1;
            end
        end
        chk("rr_grant_count", 64'(n), 64'd4);
`ifdef AVMM_ARB_FIXED_PRIO_EN
        exp_order = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_order = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        for (int k = 0; k < 4; k++)
            if (k < n) chk($sformatf("arb_grant%0d", k), 64'(order[k]), 64'(exp_order[k]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
